// File: rtl/perceptron_bpred.sv
// Perceptron branch predictor: registered fetch prediction, execute-side training and history repair.
// Define PERCEPTRON_DEBUG_EN to build the prediction/update/miss counters behind the debug readback.
module perceptron_bpred #(
    parameter int HIST_LEN    = 16,
    parameter int TABLE_DEPTH = 64,
    parameter int WEIGHT_W    = 8,
    parameter int THETA       = 44,
    localparam int IDX_W      = $clog2(TABLE_DEPTH),
    localparam int SUM_W      = WEIGHT_W + $clog2(HIST_LEN + 1),
    localparam int DATA_W     = HIST_LEN + SUM_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       fetch_bpredictor_PC,
    input  logic              soin_bpredictor_stall,
    output logic              bpredictor_fetch_p_dir,
    output logic [DATA_W-1:0] bpredictor_fetch_p_data,
    input  logic              execute_bpredictor_update,
    input  logic [31:0]       execute_bpredictor_PC4,
    input  logic              execute_bpredictor_dir,
    input  logic              execute_bpredictor_miss,
    input  logic [DATA_W-1:0] execute_bpredictor_data,
    input  logic [1:0]        soin_bpredictor_debug_sel,
    output logic [31:0]       bpredictor_soin_debug
);

    localparam int ROW_W = (HIST_LEN + 1) * WEIGHT_W;
    localparam logic signed [WEIGHT_W-1:0] W_MAX     = {1'b0, {(WEIGHT_W-1){1'b1}}};
    localparam logic signed [WEIGHT_W-1:0] W_MIN     = {1'b1, {(WEIGHT_W-1){1'b0}}};
    localparam logic signed [WEIGHT_W-1:0] W_ONE     = WEIGHT_W'(1);
    localparam logic signed [SUM_W-1:0]    THETA_POS = SUM_W'(THETA);
    localparam logic signed [SUM_W-1:0]    THETA_NEG = SUM_W'(-THETA);

    function automatic logic signed [SUM_W-1:0] sext(input logic signed [WEIGHT_W-1:0] w);
        return {{(SUM_W-WEIGHT_W){w[WEIGHT_W-1]}}, w};
    endfunction

    function automatic logic signed [WEIGHT_W-1:0] sat_step(input logic signed [WEIGHT_W-1:0] w,
                                                            input logic up);
        if (up) return (w == W_MAX) ? w : w + W_ONE;
        else    return (w == W_MIN) ? w : w - W_ONE;
    endfunction

    // Each row packs {w(H), ..., w1, w0}; w0 is the bias.
    logic [ROW_W-1:0]           rows [TABLE_DEPTH];
    logic [HIST_LEN-1:0]        sghr;
    logic [HIST_LEN-1:0]        cghr;

    logic [IDX_W-1:0]           pred_row;
    logic [ROW_W-1:0]           pred_vec;
    logic signed [SUM_W-1:0]    pred_sum;
    logic                       pred_taken;

    always_comb begin
        pred_row = fetch_bpredictor_PC[IDX_W+1:2];
        pred_vec = rows[pred_row];
        pred_sum = sext(pred_vec[WEIGHT_W-1:0]);
        for (int i = 0; i < HIST_LEN; i++) begin
            if (sghr[i]) pred_sum = pred_sum + sext(pred_vec[(i+1)*WEIGHT_W +: WEIGHT_W]);
            else         pred_sum = pred_sum - sext(pred_vec[(i+1)*WEIGHT_W +: WEIGHT_W]);
        end
        pred_taken = ~pred_sum[SUM_W-1];
    end

    logic [31:0]                upd_pc;
    logic [IDX_W-1:0]           upd_row;
    logic [HIST_LEN-1:0]        upd_hist;
    logic signed [SUM_W-1:0]    upd_sum;
    logic                       upd_train;
    logic [HIST_LEN:0]          step_up;
    logic [ROW_W-1:0]           upd_vec;
    logic [ROW_W-1:0]           trained_row;

    assign upd_pc    = execute_bpredictor_PC4 - 32'd4;
    assign upd_row   = upd_pc[IDX_W+1:2];
    assign upd_hist  = execute_bpredictor_data[DATA_W-1:SUM_W];
    assign upd_sum   = execute_bpredictor_data[SUM_W-1:0];
    assign upd_train = execute_bpredictor_update &&
                       ((~upd_sum[SUM_W-1] != execute_bpredictor_dir) ||
                        (upd_sum >= THETA_NEG && upd_sum <= THETA_POS));
    // Bias moves toward the outcome; history weights move up when their bit agreed with it.
    assign step_up   = {~(upd_hist ^ {HIST_LEN{execute_bpredictor_dir}}), execute_bpredictor_dir};

    always_comb begin
        upd_vec     = rows[upd_row];
        trained_row = '0;
        for (int i = 0; i <= HIST_LEN; i++) begin
            trained_row[i*WEIGHT_W +: WEIGHT_W] = sat_step(upd_vec[i*WEIGHT_W +: WEIGHT_W], step_up[i]);
        end
    end

    for (genvar r = 0; r < TABLE_DEPTH; r++) begin : g_row
        logic [ROW_W-1:0] row_q;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                row_q <= '0;
            end else if (upd_train && upd_row == IDX_W'(r)) begin
                row_q <= trained_row;
            end
        end
        assign rows[r] = row_q;
    end

    // Recovery is written last so it overrides the speculative shift of the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bpredictor_fetch_p_dir  <= 1'b0;
            bpredictor_fetch_p_data <= '0;
            sghr                    <= '0;
            cghr                    <= '0;
        end else begin
            if (!soin_bpredictor_stall) begin
                bpredictor_fetch_p_dir  <= pred_taken;
                bpredictor_fetch_p_data <= {sghr, pred_sum};
                sghr                    <= {sghr[HIST_LEN-2:0], pred_taken};
            end
            if (execute_bpredictor_update) begin
                cghr <= {cghr[HIST_LEN-2:0], execute_bpredictor_dir};
                if (execute_bpredictor_miss) begin
                    sghr <= {cghr[HIST_LEN-2:0], execute_bpredictor_dir};
                end
            end
        end
    end

    logic unused_addr_bits;
    assign unused_addr_bits = ^{fetch_bpredictor_PC[31:IDX_W+2], fetch_bpredictor_PC[1:0],
                                upd_pc[31:IDX_W+2], upd_pc[1:0]};

`ifdef PERCEPTRON_DEBUG_EN
    logic [31:0] pred_cnt;
    logic [31:0] upd_cnt;
    logic [31:0] miss_cnt;
    logic [31:0] debug_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pred_cnt <= '0;
            upd_cnt  <= '0;
            miss_cnt <= '0;
            debug_q  <= '0;
        end else begin
            if (!soin_bpredictor_stall) pred_cnt <= pred_cnt + 32'd1;
            if (execute_bpredictor_update) upd_cnt <= upd_cnt + 32'd1;
            if (execute_bpredictor_update && execute_bpredictor_miss) miss_cnt <= miss_cnt + 32'd1;
            case (soin_bpredictor_debug_sel)
                2'd0:    debug_q <= pred_cnt;
                2'd1:    debug_q <= upd_cnt;
                2'd2:    debug_q <= miss_cnt;
                default: debug_q <= 32'(sghr);
            endcase
        end
    end

    assign bpredictor_soin_debug = debug_q;
`else
    logic unused_debug_sel;
    assign unused_debug_sel      = ^soin_bpredictor_debug_sel;
    assign bpredictor_soin_debug = '0;
`endif

endmodule

// File: tb/tb_perceptron_bpred.sv
// Bench for perceptron_bpred: directed test-plan sequence plus random traffic against an arithmetic model.
module tb_perceptron_bpred;

    localparam int HIST_LEN    = 16;
    localparam int TABLE_DEPTH = 64;
    localparam int WEIGHT_W    = 8;
    localparam int THETA       = 44;
    localparam int SUM_W       = WEIGHT_W + $clog2(HIST_LEN + 1);
    localparam int DATA_W      = HIST_LEN + SUM_W;
    localparam int W_HI        = (1 << (WEIGHT_W - 1)) - 1;
    localparam int W_LO        = -(1 << (WEIGHT_W - 1));
    localparam logic [DATA_W-1:0] SAT_DATA  = {16'hFFFF, 13'd2159};
    localparam logic [DATA_W-1:0] SAT_TRAIN = {16'hFFFF, 13'h1FFF};

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       fetch_pc;
    logic              stall;
    logic              p_dir;
    logic [DATA_W-1:0] p_data;
    logic              upd;
    logic [31:0]       upd_pc4;
    logic              upd_dir;
    logic              upd_miss;
    logic [DATA_W-1:0] upd_data;
    logic [1:0]        dbg_sel;
    logic [31:0]       dbg;

    int compared   = 0;
    int mismatched = 0;
    bit running    = 1'b0;

    perceptron_bpred #(
        .HIST_LEN   (HIST_LEN),
        .TABLE_DEPTH(TABLE_DEPTH),
        .WEIGHT_W   (WEIGHT_W),
        .THETA      (THETA)
    ) dut (
        .clk                       (clk),
        .reset                     (rst_n),
        .fetch_bpredictor_PC       (fetch_pc),
        .soin_bpredictor_stall     (stall),
        .bpredictor_fetch_p_dir    (p_dir),
        .bpredictor_fetch_p_data   (p_data),
        .execute_bpredictor_update (upd),
        .execute_bpredictor_PC4    (upd_pc4),
        .execute_bpredictor_dir    (upd_dir),
        .execute_bpredictor_miss   (upd_miss),
        .execute_bpredictor_data   (upd_data),
        .soin_bpredictor_debug_sel (dbg_sel),
        .bpredictor_soin_debug     (dbg)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer weights and history bit vectors.
    int                  w_m [TABLE_DEPTH][HIST_LEN+1];
    bit [HIST_LEN-1:0]   sghr_m, cghr_m, sghr_nxt, m_h;
    bit                  exp_dir, m_t;
    bit [DATA_W-1:0]     exp_data;
    bit [31:0]           exp_debug;
    bit [SUM_W-1:0]      m_y_bits;
    int unsigned         pred_cnt_m, upd_cnt_m, miss_cnt_m;
    int                  m_row, m_y, m_yy;

    function automatic int clamp(input int v);
        if (v > W_HI) return W_HI;
        if (v < W_LO) return W_LO;
        return v;
    endfunction

    function automatic int model_sum(input int row);
        int s = w_m[row][0];
        for (int i = 0; i < HIST_LEN; i++) s += sghr_m[i] ? w_m[row][i+1] : -w_m[row][i+1];
        return s;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < TABLE_DEPTH; r++)
                for (int i = 0; i <= HIST_LEN; i++) w_m[r][i] = 0;
            sghr_m = '0; cghr_m = '0; exp_dir = 1'b0; exp_data = '0; exp_debug = '0;
            pred_cnt_m = 0; upd_cnt_m = 0; miss_cnt_m = 0;
        end else begin
`ifdef PERCEPTRON_DEBUG_EN
            case (dbg_sel)
                2'd0:    exp_debug = pred_cnt_m;
                2'd1:    exp_debug = upd_cnt_m;
                2'd2:    exp_debug = miss_cnt_m;
                default: exp_debug = 32'(sghr_m);
            endcase
`endif
            sghr_nxt = sghr_m;
            if (!stall) begin
                m_row    = int'((fetch_pc / 4) % TABLE_DEPTH);
                m_y      = model_sum(m_row);
                exp_dir  = (m_y >= 0);
                m_y_bits = m_y[SUM_W-1:0];
                exp_data = {sghr_m, m_y_bits};
                sghr_nxt = {sghr_m[HIST_LEN-2:0], exp_dir};
                pred_cnt_m++;
            end
            if (upd) begin
                m_row = int'(((upd_pc4 - 32'd4) / 4) % TABLE_DEPTH);
                m_t   = upd_dir;
                m_h   = upd_data[DATA_W-1:SUM_W];
                m_yy  = int'($signed(upd_data[SUM_W-1:0]));
                if (((m_yy >= 0) != m_t) || (m_yy >= -THETA && m_yy <= THETA)) begin
                    w_m[m_row][0] = clamp(w_m[m_row][0] + (m_t ? 1 : -1));
                    for (int i = 0; i < HIST_LEN; i++)
                        w_m[m_row][i+1] = clamp(w_m[m_row][i+1] + ((m_h[i] == m_t) ? 1 : -1));
                end
                if (upd_miss) sghr_nxt = {cghr_m[HIST_LEN-2:0], m_t};
                cghr_m = {cghr_m[HIST_LEN-2:0], m_t};
                upd_cnt_m++;
                if (upd_miss) miss_cnt_m++;
            end
            sghr_m = sghr_nxt;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle's inputs at a falling edge and return at the next falling edge.
    task automatic applyStimulus(input logic st, input logic [31:0] pc, input logic up,
                                 input logic [31:0] pc4, input logic d, input logic m,
                                 input logic [DATA_W-1:0] dat, input logic [1:0] sel);
        stall = st; fetch_pc = pc; upd = up; upd_pc4 = pc4;
        upd_dir = d; upd_miss = m; upd_data = dat; dbg_sel = sel;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (running) begin
            checkOutput("model_p_dir",  32'(p_dir),  32'(exp_dir));
            checkOutput("model_p_data", 32'(p_data), 32'(exp_data));
            checkOutput("model_debug",  dbg,         exp_debug);
        end
    end

    logic [31:0]       r_pc, r_pc4;
    logic [DATA_W-1:0] r_data;
    int                r_y;

    initial begin
        rst_n = 1'b0;
        stall = 1'b0; fetch_pc = '0; upd = 1'b0; upd_pc4 = '0;
        upd_dir = 1'b0; upd_miss = 1'b0; upd_data = '0; dbg_sel = '0;
        running = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_p_dir",  32'(p_dir),  32'd0);
        checkOutput("reset_p_data", 32'(p_data), 32'd0);
        checkOutput("reset_debug",  dbg,         32'd0);
        rst_n = 1'b1;

        applyStimulus(1'b0, 32'h80, 1'b0, '0, 1'b0, 1'b0, '0, 2'd3);
        checkOutput("first_p_dir", 32'(p_dir), 32'd1);
        checkOutput("first_y",     32'(p_data[SUM_W-1:0]), 32'd0);
        applyStimulus(1'b1, 32'h80, 1'b0, '0, 1'b0, 1'b0, '0, 2'd3);
`ifdef PERCEPTRON_DEBUG_EN
        checkOutput("debug_sghr", dbg, 32'h1);
`else
        checkOutput("debug_tied", dbg, 32'h0);
`endif

        applyStimulus(1'b1, 32'h80, 1'b1, 32'h84, 1'b0, 1'b1, '0, 2'd3);
        applyStimulus(1'b0, 32'h80, 1'b0, '0, 1'b0, 1'b0, '0, 2'd3);
        checkOutput("trained_p_dir", 32'(p_dir), 32'd0);
        checkOutput("trained_y",     32'(p_data[SUM_W-1:0]), 32'h1FEF);
        checkOutput("trained_hist",  32'(p_data[DATA_W-1:SUM_W]), 32'h0);

        repeat (200) applyStimulus(1'b1, 32'h80, 1'b1, 32'h84, 1'b1, 1'b0, SAT_TRAIN, 2'd0);
        applyStimulus(1'b1, 32'h80, 1'b1, 32'h84, 1'b1, 1'b1, SAT_TRAIN, 2'd0);
        applyStimulus(1'b0, 32'h80, 1'b0, '0, 1'b0, 1'b0, '0, 2'd0);
        checkOutput("sat_p_dir",  32'(p_dir),  32'd1);
        checkOutput("sat_p_data", 32'(p_data), 32'(SAT_DATA));

        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, $urandom(), 1'b0, '0, 1'b0, 1'b0, '0, 2'd0);
            checkOutput("stall_p_dir",  32'(p_dir),  32'd1);
            checkOutput("stall_p_data", 32'(p_data), 32'(SAT_DATA));
        end
`ifdef PERCEPTRON_DEBUG_EN
        checkOutput("stall_pred_cnt", dbg, 32'd3);
`endif

        for (int k = 0; k < 16; k++)
            applyStimulus(1'b1, 32'h80, 1'b1, 32'h104, (k >= 14), 1'b0, '0, 2'd1);
        applyStimulus(1'b0, 32'h80, 1'b1, 32'h104, 1'b0, 1'b1, '0, 2'd2);
        checkOutput("collide_p_dir",  32'(p_dir),  32'd1);
        checkOutput("collide_p_data", 32'(p_data), 32'(SAT_DATA));
        applyStimulus(1'b0, 32'h80, 1'b0, '0, 1'b0, 1'b0, '0, 2'd3);
        checkOutput("recover_hist", 32'(p_data[DATA_W-1:SUM_W]), 32'h0006);

        for (int n = 0; n < 1500; n++) begin
            r_pc  = ($urandom() & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2) |
                    32'($urandom_range(0, 3));
            r_pc4 = 32'h1000 + (32'($urandom_range(0, 7)) << 2) + 32'd4;
            if ($urandom_range(0, 1) == 1) r_y = int'($urandom_range(0, 120)) - 60;
            else                           r_y = int'($urandom_range(0, 8191)) - 4096;
            r_data = {16'($urandom()), 13'(r_y)};
            applyStimulus(($urandom_range(0, 3) == 0), r_pc, ($urandom_range(0, 1) == 1), r_pc4,
                          ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0), r_data,
                          2'($urandom_range(0, 3)));
        end

        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_p_dir",  32'(p_dir),  32'd0);
        checkOutput("async_p_data", 32'(p_data), 32'd0);
        checkOutput("async_debug",  dbg,         32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, $urandom(), 1'b0, '0, 1'b0, 1'b0, '0, 2'd0);
        checkOutput("post_reset_p_dir", 32'(p_dir),  32'd1);
        checkOutput("post_reset_data",  32'(p_data), 32'd0);

        running = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/perceptron_bpred.md
# perceptron_bpred

Parametrised perceptron branch predictor, successor to the fixed-size `bpredTop`. It sits between fetch and execute:
- Fetch side: a registered taken/not-taken prediction per non-stalled cycle, plus a snapshot of the history and perceptron sum used to make it.
- Execute side: trains one weight row per resolved branch and repairs the speculative global history on a misprediction.

History length, table depth and weight width are configurable.

## Interface
- `HIST_LEN`, 16: global history bits (H); weights per row = H+1, including the bias.
- `TABLE_DEPTH`, 64: perceptron rows; power of two; IDX_W = clog2(TABLE_DEPTH).
- `WEIGHT_W`, 8: signed weight width (W).
- `THETA`, 44: training threshold.
- Derived: SUM_W = W + clog2(H+1); DATA_W = H + SUM_W.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `fetch_bpredictor_PC`  in  32  fetch PC to predict.
- `soin_bpredictor_stall`  in  1  hold all prediction state.
- `bpredictor_fetch_p_dir`  out  1  prediction, 1 = taken.
- `bpredictor_fetch_p_data`  out  DATA_W  {history used [H-1:0], sum y [SUM_W-1:0]}; travels down the pipe.
- `execute_bpredictor_update`  in  1  resolved conditional branch this cycle.
- `execute_bpredictor_PC4`  in  32  resolved branch PC+4.
- `execute_bpredictor_dir`  in  1  actual direction.
- `execute_bpredictor_miss`  in  1  branch was mispredicted.
- `execute_bpredictor_data`  in  DATA_W  p_data that accompanied this branch.
- `soin_bpredictor_debug_sel`  in  2  debug mux select.
- `bpredictor_soin_debug`  out  32  debug readback.

## Operation
- State:
  - Weight array W[TABLE_DEPTH][H+1], signed, held in flops.
  - Speculative history sGHR and committed history cGHR, H bits each, newest outcome at bit 0.
- Predict (stall = 0):
  - Row index = PC[IDX_W+1:2].
  - y = w0 + Σ(sGHR[i] ? +w(i+1) : −w(i+1)) for i = 0..H-1, computed at SUM_W bits, sign-extended.
  - p_dir ← (y ≥ 0).
  - p_data ← {sGHR, y}.
  - sGHR ← {sGHR[H-2:0], p_dir_next}.
- Train (update = 1):
  - Row index = (PC4 − 4)[IDX_W+1:2].
  - Let t = dir, h = data[DATA_W-1:SUM_W], y = data[SUM_W-1:0] (signed).
  - Train iff (y ≥ 0) ≠ t, or |y| ≤ THETA.
  - When training:
    - Bias: w0 += t ? +1 : −1.
    - History weights: w(i+1) += (h[i] == t) ? +1 : −1.
    - All weights saturate at [−2^(W-1), 2^(W-1)−1] and never wrap.
  - cGHR ← {cGHR[H-2:0], t} on every update, whether or not the row trained.
- Recovery (update = 1 and miss = 1):
  - sGHR ← {cGHR[H-2:0], t}.
  - This overrides any predict shift in the same cycle.
- Predict and train on the same row in the same cycle: the prediction uses the pre-update weights; there is no bypass.
- Stall = 1: p_dir, p_data and sGHR hold. Training and cGHR still update. Recovery still applies.

## Timing
- Prediction latency: PC presented in cycle n → p_dir/p_data valid after the rising edge ending cycle n, held until the next non-stalled edge.
- Training takes effect at the edge ending the update cycle. The first prediction that observes the new weights is the one whose PC is presented in the following cycle.
- Reset (asynchronous, immediate) clears:
  - p_dir = 0, p_data = 0;
  - all weights = 0;
  - sGHR = cGHR = 0;
  - debug counters = 0, bpredictor_soin_debug = 0.
- Reset deassertion mid-stream: the first non-stalled edge predicts taken, because y = 0.
- No back-pressure; update is accepted every cycle, including on consecutive cycles to the same row.

## Configuration
- `PERCEPTRON_DEBUG_EN` defined:
  - Three 32-bit wrapping counters: predictions (non-stalled cycles), updates, misses.
  - Readback by sel: 0 = predictions, 1 = updates, 2 = misses, 3 = sGHR zero-extended.
  - Output is registered (one-cycle latency from sel).
- Not defined: no counters are built and bpredictor_soin_debug is tied to 0.

## Test plan
- Reset, stall = 0, PC = 0x80 for one edge → p_dir = 1, p_data[SUM_W-1:0] = 0; debug sel = 3 reads 0x1 (sGHR).
- Update with PC4 = 0x84, dir = 0, miss = 1, data = 0 → row 0x20 has w0 = −1, all other weights +1; sGHR = 0. Then predict PC 0x80 → y = −17, p_dir = 0.
- Saturation: 200 updates to row 0x20 with dir = 1, h = all ones, y field = −1 (forces training) → all 17 weights = 127, no wrap. Prediction with sGHR = all ones → y = 2159, p_dir = 1.
- Stall held 3 cycles while PC changes → p_dir, p_data and sGHR unchanged; prediction counter +0.
- In the same cycle, fetch predicts taken and execute updates with miss = 1, dir = 0, cGHR = 0x0003 → sGHR = 0x0006; no fetch shift is applied.
- Assert reset between edges mid-training → all outputs 0 within the same cycle; a later predict of any PC gives p_dir = 1, y = 0.
